// File: rtl/alu_exec_unit.sv
// Registered, handshaked ALU execute stage with valid/ready on both sides.
// Optional iterative SLL (op 011) is enabled by defining ALU_SHIFT_EN.
//
// state | meaning
// IDLE  | ready for a request; in_ready = 1
// SHIFT | iterative left shift in progress (ALU_SHIFT_EN only)
// DONE  | result/flags valid, held until out_ready
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       ALU_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
`ifdef ALU_SHIFT_EN
  localparam logic [1:0] ST_SHIFT = 2'd1;
`endif
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b110;
`ifdef ALU_SHIFT_EN
  localparam logic [2:0] OP_SLL = 3'b011;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

`ifdef ALU_SHIFT_EN
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_shl;
  logic [CNT_W-1:0] sll_amt;

  assign shreg_shl = {shreg_q[WIDTH-2:0], 1'b0};
  assign sll_amt   = B[CNT_W-1:0];
`endif

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign sum  = A + B;
  assign diff = A - B;
  // Direct signed compare rather than diff's sign bit, so SLT stays correct when A-B overflows.
  assign slt  = ($signed(A) < $signed(B));

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ALU_op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`ifdef ALU_SHIFT_EN
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          result_d = alu_res;
          zero_d   = (alu_res == '0);
          ovf_d    = alu_ovf;
          state_d  = ST_DONE;
`ifdef ALU_SHIFT_EN
          if (ALU_op == OP_SLL) begin
            ovf_d = 1'b0;
            if (sll_amt == '0) begin
              result_d = A;
              zero_d   = (A == '0);
            end else begin
              shreg_d = A;
              cnt_d   = sll_amt;
              state_d = ST_SHIFT;
            end
          end
`endif
        end
      end
`ifdef ALU_SHIFT_EN
      ST_SHIFT: begin
        shreg_d = shreg_shl;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          result_d = shreg_shl;
          zero_d   = (shreg_shl == '0);
          ovf_d    = 1'b0;
          state_d  = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ALU_SHIFT_EN
      shreg_q  <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`ifdef ALU_SHIFT_EN
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; SLL cases run when ALU_SHIFT_EN is defined.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  ALU_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ALU_op    (ALU_op),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request (inputs change #1 after posedge), then waits for out_valid
  // with a bounded budget and checks latency, result and flags.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_z, input logic exp_ovf);
    int lat;
    ALU_op    = op;
    A         = a;
    B         = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({tag, "/in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    A        = ~a;
    B        = ~b;
    ALU_op   = 3'b111;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/result"}, result, exp_res);
    chk({tag, "/zero"}, {31'd0, zero}, {31'd0, exp_z});
    chk({tag, "/overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    @(posedge clk); #1;
    chk({tag, "/out_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ALU_op    = 3'b000;
    A         = 32'd0;
    B         = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/result", result, 32'd0);
    chk("reset/zero", {31'd0, zero}, 32'd0);
    chk("reset/overflow", {31'd0, overflow}, 32'd0);
    chk("reset/out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset/in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_ovf",  3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 1'b0, 1'b1);
    run_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 1'b1, 1'b0);
    run_op("sub_zero", 3'b100, 32'h0000_0005, 32'h0000_0005, 1, 32'h0000_0000, 1'b1, 1'b0);
    run_op("sub_ovf",  3'b100, 32'h8000_0000, 32'h0000_0001, 1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_op("slt_neg",  3'b110, 32'h8000_0000, 32'h0000_0001, 1, 32'h0000_0001, 1'b0, 1'b0);
    run_op("slt_pos",  3'b110, 32'h0000_0001, 32'h8000_0000, 1, 32'h0000_0000, 1'b1, 1'b0);
    run_op("slt_vov",  3'b110, 32'h7FFF_FFFF, 32'h8000_0000, 1, 32'h0000_0000, 1'b1, 1'b0);
    run_op("slt_vov2", 3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 1, 32'h0000_0001, 1'b0, 1'b0);
    run_op("and",      3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, 1'b0, 1'b0);
    run_op("or",       3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hFFF0_FFF0, 1'b0, 1'b0);
    run_op("xor",      3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'h0FF0_0FF0, 1'b0, 1'b0);
    run_op("rsv111",   3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 1, 32'h0000_0000, 1'b1, 1'b0);

`ifdef ALU_SHIFT_EN
    run_op("sll4",     3'b011, 32'h0000_0003, 32'h0000_0004, 5,  32'h0000_0030, 1'b0, 1'b0);
    run_op("sll0",     3'b011, 32'h1234_5678, 32'h0000_0000, 1,  32'h1234_5678, 1'b0, 1'b0);
    run_op("sll31",    3'b011, 32'h0000_0001, 32'h0000_001F, 32, 32'h8000_0000, 1'b0, 1'b0);
    run_op("sll_hi",   3'b011, 32'h0000_0003, 32'hFFFF_FFE4, 5,  32'h0000_0030, 1'b0, 1'b0);
    run_op("sll_out",  3'b011, 32'h8000_0000, 32'h0000_0001, 2,  32'h0000_0000, 1'b1, 1'b0);

    // Reset three cycles into a 20-step shift.
    ALU_op   = 3'b011;
    A        = 32'h0000_0001;
    B        = 32'd20;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_shift/in_ready_busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_shift/out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_shift/result", result, 32'd0);
    chk("rst_shift/in_ready", {31'd0, in_ready}, 32'd1);
    repeat (20) begin
      @(posedge clk); #1;
      chk("rst_shift/no_pulse", {31'd0, out_valid}, 32'd0);
    end
`else
    run_op("rsv011",   3'b011, 32'h0000_0003, 32'h0000_0004, 1, 32'h0000_0000, 1'b1, 1'b0);
`endif

    // Backpressure: DONE holds for 5 cycles, new requests ignored.
    out_ready = 1'b0;
    ALU_op    = 3'b000;
    A         = 32'h0000_0010;
    B         = 32'h0000_0020;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    ALU_op = 3'b100;
    A      = 32'h0000_0001;
    B      = 32'h0000_0001;
    chk("bp/out_valid", {31'd0, out_valid}, 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp/hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp/hold_result", result, 32'h0000_0030);
      chk("bp/hold_zero", {31'd0, zero}, 32'd0);
      chk("bp/in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp/release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp/release_ready", {31'd0, in_ready}, 32'd1);
    chk("bp/release_result", result, 32'h0000_0030);
    repeat (2) @(posedge clk);
    #1;
    chk("bp/no_second", {31'd0, out_valid}, 32'd0);

    // Reset while holding DONE discards the result.
    out_ready = 1'b0;
    ALU_op    = 3'b000;
    A         = 32'h0000_0001;
    B         = 32'h0000_0002;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_done/pre_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    chk("rst_done/out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done/result", result, 32'd0);
    chk("rst_done/in_ready", {31'd0, in_ready}, 32'd1);

    run_op("post_rst_add", 3'b000, 32'h0000_0064, 32'h0000_00C8, 1, 32'h0000_012C, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
